// File: rtl/alu_pkg.sv
// Shared constants and types for the 8-bit ALU datapath (operand mux,
// ALU, result demux).
//   WIDTH : data word width
//   LANES : number of mux/demux lanes
//   SEL_W : lane select width
//   OCC_W : width of a 0..LANES lane count
package alu_pkg;

  localparam int WIDTH = 8;
  localparam int LANES = 8;
  localparam int SEL_W = 3;
  localparam int OCC_W = 4;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [OCC_W-1:0] occ_t;

  function automatic occ_t count_ones(input logic [LANES-1:0] bits);
    occ_t cnt;
    cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + occ_t'(bits[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/demux_lane.sv
// Single-entry lane buffer for the result demux.
//   clk, rst_n : clock, async active-low reset
//   wr_en      : store wr_data into this lane (already qualified by ready)
//   wr_data    : word to store
//   ack        : consumer takes the held word this cycle
//   flush      : clear valid; a same-cycle write is discarded
//   data       : held word (kept after ack until the next write)
//   valid      : lane holds an unconsumed word
//   ready      : lane can accept a word this cycle
//   ack_taken  : ack hit a full lane (counts toward occupancy)
module demux_lane
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  word_t wr_data,
  input  logic  ack,
  input  logic  flush,
  output word_t data,
  output logic  valid,
  output logic  ready,
  output logic  ack_taken
);

  // An ack frees the slot in the same cycle, so a full lane being acked
  // can take a new word without a bubble.
  assign ready     = !valid || ack;
  assign ack_taken = ack && valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      if (wr_en && !flush) begin
        data <= wr_data;
      end
      // Write beats ack so a reload on an acked lane keeps valid high.
      if (flush) begin
        valid <= 1'b0;
      end else if (wr_en) begin
        valid <= 1'b1;
      end else if (ack) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/demux_1to8_reg.sv
// Registered 1-to-8 result demux with per-lane valid/ack handshake.
//   clk, rst_n : clock, async active-low reset
//   in_valid   : producer offers in_data to lane in_select
//   in_select  : destination lane 0..7
//   in_data    : data word
//   in_ready   : selected lane can accept (combinational, ignores in_valid)
//   flush      : synchronous clear of all lane valid flags
//   out_data   : packed lane words, lane k at [8k+7:8k]
//   out_valid  : per-lane unconsumed-data flags
//   out_ack    : per-lane consumer acknowledge
//   occupancy  : registered count of set out_valid bits
module demux_1to8_reg
  import alu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  sel_t                   in_select,
  input  word_t                  in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ack,
  output occ_t                   occupancy
);

  logic [LANES-1:0] lane_ready;
  logic [LANES-1:0] lane_wr;
  logic [LANES-1:0] ack_taken;
  word_t            lane_data [LANES];
  logic             wr_fire;
  occ_t             occ_next;

  assign in_ready = lane_ready[in_select];
  assign wr_fire  = in_valid && in_ready;

  always_comb begin
    lane_wr = '0;
    if (wr_fire) begin
      lane_wr[in_select] = 1'b1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    demux_lane u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (lane_wr[k]),
      .wr_data   (in_data),
      .ack       (out_ack[k]),
      .flush     (flush),
      .data      (lane_data[k]),
      .valid     (out_valid[k]),
      .ready     (lane_ready[k]),
      .ack_taken (ack_taken[k])
    );
    assign out_data[k*WIDTH +: WIDTH] = lane_data[k];
  end

  // Write and acks are counted independently: a reload on an acked lane
  // nets to zero, matching its valid bit staying set.
  always_comb begin
    occ_next = occupancy + occ_t'(wr_fire) - count_ones(ack_taken);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_next;
    end
  end

endmodule

// File: tb/tb_demux_1to8_reg.sv
module tb_demux_1to8_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_select;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        flush;
  logic [63:0] out_data;
  logic [7:0]  out_valid;
  logic [7:0]  out_ack;
  logic [3:0]  occupancy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_data  [8];
  bit         m_valid [8];

  demux_1to8_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_select (in_select),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int k = 0; k < 8; k++) c += m_valid[k] ? 1 : 0;
    return c;
  endfunction

  function automatic logic [7:0] m_valid_bits();
    logic [7:0] v = '0;
    for (int k = 0; k < 8; k++) v[k] = m_valid[k];
    return v;
  endfunction

  task automatic m_clear();
    for (int k = 0; k < 8; k++) begin
      m_data[k]  = 8'h00;
      m_valid[k] = 1'b0;
    end
  endtask

  task automatic check_state();
    chk("out_valid", out_valid, m_valid_bits());
    chk("occupancy", occupancy, m_count());
    chk("occ_popcount", occupancy, $countones(out_valid));
    for (int k = 0; k < 8; k++) chk($sformatf("lane%0d_data", k), out_data[k*8 +: 8], m_data[k]);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_select = 3'd0; in_data = 8'h00; out_ack = 8'h00; flush = 1'b0;
  endtask

  // One clock of stimulus; model applies acks, then the write, then flush.
  task automatic cycle(input bit v, input logic [2:0] sel, input logic [7:0] d,
                       input logic [7:0] ack, input bit fl);
    bit exp_ready, fire;
    in_valid = v; in_select = sel; in_data = d; out_ack = ack; flush = fl;
    #1;
    exp_ready = !m_valid[sel] || ack[sel];
    chk("in_ready", in_ready, exp_ready);
    fire = v && exp_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) if (ack[k]) m_valid[k] = 1'b0;
    if (fire && !fl) begin
      m_data[sel]  = d;
      m_valid[sel] = 1'b1;
    end
    if (fl) for (int k = 0; k < 8; k++) m_valid[k] = 1'b0;
    check_state();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, out_valid, 8'h00);
    chk({tag, "_data"}, out_data, 64'h0);
    chk({tag, "_occ"}, occupancy, 4'd0);
    for (int s = 0; s < 8; s++) begin
      in_select = 3'(s);
      #0;
      chk({tag, "_ready"}, in_ready, 1'b1);
    end
    in_select = 3'd0;
  endtask

  initial begin
    m_clear();
    idle();
    rst_n = 1'b0;
    #1;
    check_reset_values("rst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill all lanes with one-hot data.
    for (int k = 0; k < 8; k++) cycle(1'b1, 3'(k), 8'(1 << k), 8'h00, 1'b0);
    chk("fill_valid", out_valid, 8'hFF);
    chk("fill_occ", occupancy, 4'd8);
    idle();
    for (int s = 0; s < 8; s++) begin
      in_select = 3'(s);
      #1;
      chk("full_ready", in_ready, 1'b0);
    end

    // Back-pressure then same-cycle ack+reload on lane 3.
    cycle(1'b1, 3'd3, 8'h77, 8'h00, 1'b0);
    chk("lane3_blocked", out_data[31:24], 8'h08);
    cycle(1'b1, 3'd3, 8'hA5, 8'h08, 1'b0);
    chk("lane3_reload", out_data[31:24], 8'hA5);
    chk("lane3_occ", occupancy, 4'd8);

    // Ack lane 5, ack it again while empty, refill, then multi-lane ack.
    cycle(1'b0, 3'd0, 8'h00, 8'h20, 1'b0);
    cycle(1'b0, 3'd0, 8'h00, 8'h20, 1'b0);
    chk("empty_ack_valid", out_valid, 8'hDF);
    chk("empty_ack_occ", occupancy, 4'd7);
    cycle(1'b1, 3'd5, 8'h20, 8'h00, 1'b0);
    cycle(1'b0, 3'd0, 8'h00, 8'h85, 1'b0);
    chk("ack027_valid", out_valid, 8'h7A);
    chk("ack027_occ", occupancy, 4'd5);

    // Empty lane 1, then flush together with a write to it.
    cycle(1'b0, 3'd0, 8'h00, 8'h02, 1'b0);
    cycle(1'b1, 3'd1, 8'h3C, 8'h00, 1'b1);
    chk("flush_valid", out_valid, 8'h00);
    chk("flush_occ", occupancy, 4'd0);
    chk("flush_nowrite", out_data[15:8], 8'h02);

    // Asynchronous reset with four lanes full, then resume.
    for (int k = 0; k < 4; k++) cycle(1'b1, 3'(k), 8'(8'h11 * (k + 1)), 8'h00, 1'b0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    m_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_state();
    cycle(1'b1, 3'd6, 8'h5A, 8'h00, 1'b0);
    chk("resume_lane6", out_data[55:48], 8'h5A);
    cycle(1'b1, 3'd2, 8'hC3, 8'h40, 1'b0);

    // Random write/ack/flush stress.
    repeat (10000) begin
      cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
            8'($urandom & $urandom), $urandom_range(0, 63) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux_1to8_reg.md
# demux_1to8_reg

Registered 1-to-8 demultiplexer with per-lane handshake: the write-side counterpart of the 8-to-1 operand mux in the 8-bit ALU datapath. It takes one 8-bit result per cycle, tagged with a 3-bit destination select, and steers it into one of eight single-entry lane buffers. Each lane holds its value with a valid flag until its consumer acknowledges it, so result routing tolerates back-pressure from slow destinations.

## Interface
- WIDTH, 8, data width per lane
- LANES, 8, number of output lanes (fixed at 8; SEL_W = 3)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer offers in_data/in_select this cycle
- in_select  in  3  destination lane index 0..7
- in_data  in  8  data word
- in_ready  out  1  lane in_select can accept this cycle (combinational)
- flush  in  1  synchronous clear of all lane valid flags
- out_data  out  64  packed lane data; lane k = bits [8k+7:8k]
- out_valid  out  8  bit k set: lane k holds unconsumed data
- out_ack  in  8  bit k: consumer of lane k takes its data this cycle
- occupancy  out  4  number of set out_valid bits, 0..8

## Operation
- Write fires when in_valid && in_ready; word stored in lane in_select, that lane's valid set.
- in_ready = !out_valid[in_select] || out_ack[in_select]; depends only on select, valid and ack of that lane, never on in_valid.
- Ack on lane k with out_valid[k]=1: valid clears at the edge, unless a write to lane k fires in the same cycle (then lane reloads, valid stays 1).
- Ack on an empty lane: ignored, no state change.
- Acks to several lanes in one cycle all take effect; at most one write per cycle.
- out_data[k] retains last written value after ack; only a write changes it.
- flush: all valid bits cleared at the edge; takes priority over any write and ack in the same cycle; in_ready is still computed normally but the accepted write is discarded. Data registers unchanged.
- occupancy is a registered count, updated each edge by (+1 write, −number of effective acks), set to 0 on flush; equals popcount(out_valid) at all times.
- in_select with in_valid=0 has no effect.

## Timing
- Reset (rst_n low, asynchronous): out_valid = 0, out_data = 0, occupancy = 0; in_ready then reads 1 for every select.
- Reset deassertion synchronous to clk by the integrator; no write fires in the cycle rst_n is low.
- Write latency: data and valid visible on out_data/out_valid the cycle after acceptance.
- Ack latency: out_valid drops the cycle after the ack edge.
- Sustained throughput: one write per cycle when target lanes are empty or being acked.
- Reset mid-operation discards all buffered data; no partial state retained.

## Structure
- Shared package alu_pkg: WIDTH, LANES, SEL_W constants (common with the mux and ALU).
- One sub-module demux_lane: single-entry buffer (data reg, valid reg, wr_en, ack, flush inputs, ready output); instantiated 8 times in a generate loop.
- Top level holds select decode, in_ready mux, occupancy counter.

## Test plan
- Reset then write 0x01,0x02,…,0x80 to lanes 0..7 on consecutive cycles -> each out_data lane matches, out_valid=0xFF, occupancy=8, in_ready=0 for every select.
- Lane 3 full, in_valid with select=3, no ack -> in_ready=0, lane 3 keeps old value 0x08; assert out_ack[3] same cycle with in_data 0xA5 -> lane 3 = 0xA5, valid stays 1, occupancy unchanged.
- Ack on empty lane 5 -> out_valid, occupancy unchanged; ack lanes 0,2,7 together from full -> out_valid=0x7A, occupancy=5, out_data unchanged.
- flush asserted with a write to empty lane 1 (0x3C) -> out_valid=0x00, occupancy=0, out_data lane 1 not 0x3C.
- rst_n pulsed low mid-sequence with 4 lanes full -> immediately out_valid=0, out_data=0, occupancy=0; writes resume normally after release.
- Random write/ack/flush stress, 10k cycles -> occupancy == popcount(out_valid) every cycle, every accepted word delivered once per ack with matching lane and value.
